// File: rtl/pause_arb_pkg.sv
// Shared types and constants for the pause arbiter: FSM state encoding,
// option bit indices and the dim delay in seconds.
package pause_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALTING,
        GRANT,
        HELD,
        RELEASE
    } state_t;

    localparam int OPT_PAUSE_IN_OSD = 0;
    localparam int OPT_DIM          = 1;
    localparam int DIM_SECONDS      = 10;

endpackage

// File: rtl/pause_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set req bit at or above ptr,
// wrapping modulo NREQ, returned one-hot together with a valid flag.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    logic [PW-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pause_arbiter.sv
// Halts the CPU for user/OSD pause or exclusive-access requesters and grants them round-robin.
// Optional video dim after a long pause is built when PAUSE_ARB_DIM_EN is defined.
module pause_arbiter
    import pause_arb_pkg::*;
#(
    parameter int          NREQ        = 4,
    parameter int          CLKSPD      = 12,
    parameter int unsigned ACK_TIMEOUT = 4096
`ifdef PAUSE_ARB_DIM_EN
    ,
    parameter int unsigned DIM_LIMIT   = CLKSPD * 1_000_000 * DIM_SECONDS
`endif
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            core_reset,
    input  logic            user_button,
    input  logic            osd_status,
    input  logic [1:0]      options,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            cpu_halt,
    input  logic            cpu_halted,
    output logic            paused,
    output logic            ack_timeout
`ifdef PAUSE_ARB_DIM_EN
    ,
    output logic            dim_video
`endif
);

    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [TW-1:0]   ack_cnt;
    logic            btn_q;
    logic            user_pause;
    logic            hold;
    logic [NREQ-1:0] pick;
    logic            pick_valid;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   next_ptr;

    assign hold   = user_pause | (osd_status & options[OPT_PAUSE_IN_OSD]);
    assign paused = cpu_halt & cpu_halted;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick),
        .valid  (pick_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) win_idx = PW'(i);
        end
        next_ptr = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            btn_q      <= 1'b0;
            user_pause <= 1'b0;
        end else begin
            btn_q <= user_button;
            if (core_reset)
                user_pause <= 1'b0;
            else if (user_button && !btn_q)
                user_pause <= ~user_pause;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            ack_cnt     <= '0;
            grant       <= '0;
            cpu_halt    <= 1'b0;
            ack_timeout <= 1'b0;
        end else begin
            ack_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req || hold) begin
                        state    <= HALTING;
                        cpu_halt <= 1'b1;
                        ack_cnt  <= '0;
                    end
                end
                HALTING: begin
                    if (cpu_halted) begin
                        ack_cnt <= '0;
                        if (pick_valid) begin
                            state <= GRANT;
                            grant <= pick;
                            ptr   <= next_ptr;
                        end else if (hold) begin
                            state <= HELD;
                        end else begin
                            state    <= RELEASE;
                            cpu_halt <= 1'b0;
                        end
                    end else if (ack_cnt == ACK_LAST) begin
                        ack_cnt     <= '0;
                        ack_timeout <= 1'b1;
                        state       <= RELEASE;
                        cpu_halt    <= 1'b0;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                GRANT: begin
                    // Winner dropped its request: give the bus back and re-arbitrate with the CPU still halted.
                    if (!(|(grant & req))) begin
                        grant   <= '0;
                        state   <= HALTING;
                        ack_cnt <= '0;
                    end
                end
                HELD: begin
                    if (|req) begin
                        state   <= HALTING;
                        ack_cnt <= '0;
                    end else if (!hold) begin
                        state    <= RELEASE;
                        cpu_halt <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!cpu_halted) state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    cpu_halt <= 1'b0;
                end
            endcase
        end
    end

`ifdef PAUSE_ARB_DIM_EN
    localparam logic [28:0] DIM_MAX = 29'(DIM_LIMIT);
    logic [28:0] dim_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dim_cnt   <= '0;
            dim_video <= 1'b0;
        end else if (paused && options[OPT_DIM]) begin
            if (dim_cnt != DIM_MAX) dim_cnt <= dim_cnt + 1'b1;
            dim_video <= (dim_cnt == DIM_MAX);
        end else begin
            dim_cnt   <= '0;
            dim_video <= 1'b0;
        end
    end
`else
    localparam int unused_clkspd = CLKSPD;
    logic unused_opt_dim;
    assign unused_opt_dim = options[OPT_DIM];
`endif

endmodule

// File: tb/tb_pause_arbiter.sv
// Directed self-checking bench for pause_arbiter (NREQ=4, ACK_TIMEOUT=16);
// the dim sequence runs only when PAUSE_ARB_DIM_EN is defined.
module tb_pause_arbiter;
    import pause_arb_pkg::*;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       core_reset;
    logic       user_button;
    logic       osd_status;
    logic [1:0] options;
    logic [3:0] req;
    logic [3:0] grant;
    logic       cpu_halt;
    logic       cpu_halted;
    logic       paused;
    logic       ack_timeout;
`ifdef PAUSE_ARB_DIM_EN
    logic       dim_video;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    pause_arbiter #(
        .NREQ        (4),
        .CLKSPD      (12),
        .ACK_TIMEOUT (16)
`ifdef PAUSE_ARB_DIM_EN
        ,
        .DIM_LIMIT   (100)
`endif
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .core_reset  (core_reset),
        .user_button (user_button),
        .osd_status  (osd_status),
        .options     (options),
        .req         (req),
        .grant       (grant),
        .cpu_halt    (cpu_halt),
        .cpu_halted  (cpu_halted),
        .paused      (paused),
        .ack_timeout (ack_timeout)
`ifdef PAUSE_ARB_DIM_EN
        ,
        .dim_video   (dim_video)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int first;
        logic halt_at_pulse;

        core_reset  = 1'b0;
        user_button = 1'b0;
        osd_status  = 1'b0;
        options     = 2'b00;
        req         = 4'b0000;
        cpu_halted  = 1'b0;
        do_reset();

        // reset state
        check("rst grant", 32'(grant), 32'h0);
        check("rst cpu_halt", 32'(cpu_halt), 32'h0);
        check("rst ack_timeout", 32'(ack_timeout), 32'h0);
        check("rst paused", 32'(paused), 32'h0);

        // single requester, CPU acknowledges late
        req = 4'b0001;
        step();
        check("t1 cpu_halt +1", 32'(cpu_halt), 32'h1);
        step(2);
        check("t1 no grant before ack", 32'(grant), 32'h0);
        step();
        cpu_halted = 1'b1;
        step();
        check("t1 grant", 32'(grant), 32'h1);
        check("t1 paused", 32'(paused), 32'h1);
        step();
        check("t1 grant held", 32'(grant), 32'h1);
        req = 4'b0000;
        step();
        check("t1 grant drop", 32'(grant), 32'h0);
        check("t1 halt kept", 32'(cpu_halt), 32'h1);
        step();
        check("t1 release halt", 32'(cpu_halt), 32'h0);
        check("t1 release st", 32'(dut.state), 32'(RELEASE));
        cpu_halted = 1'b0;
        step();
        check("t1 idle", 32'(dut.state), 32'(IDLE));

        // round-robin over 1011 from ptr 0
        do_reset();
        cpu_halted = 1'b1;
        req = 4'b1011;
        step(2);
        check("t2 grant0", 32'(grant), 32'h1);
        req = 4'b1010;
        step();
        check("t2 gap0", 32'(grant), 32'h0);
        check("t2 halt0", 32'(cpu_halt), 32'h1);
        step();
        check("t2 grant1", 32'(grant), 32'h2);
        req = 4'b1000;
        step();
        check("t2 halt1", 32'(cpu_halt), 32'h1);
        step();
        check("t2 grant3", 32'(grant), 32'h8);
        check("t2 halt3", 32'(cpu_halt), 32'h1);
        req = 4'b0000;
        step(2);
        check("t2 release", 32'(cpu_halt), 32'h0);
        cpu_halted = 1'b0;
        step();
        check("t2 idle", 32'(dut.state), 32'(IDLE));

        // halt acknowledge timeout
        req = 4'b0001;
        step();
        req = 4'b0000;
        pulses = 0;
        first = 0;
        halt_at_pulse = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (ack_timeout) begin
                pulses++;
                if (first == 0) begin
                    first = i;
                    halt_at_pulse = cpu_halt;
                end
            end
        end
        check("t3 pulse count", 32'(pulses), 32'd1);
        check("t3 pulse cycle", 32'(first), 32'd16);
        check("t3 halt dropped", 32'(halt_at_pulse), 32'h0);
        check("t3 idle", 32'(dut.state), 32'(IDLE));
        check("t3 grant", 32'(grant), 32'h0);

        // user pause, requester during HELD, core reset
        user_button = 1'b1;
        step();
        user_button = 1'b0;
        step();
        cpu_halted = 1'b1;
        step();
        check("t4 held", 32'(dut.state), 32'(HELD));
        check("t4 held grant", 32'(grant), 32'h0);
        req = 4'b0100;
        step(2);
        check("t4 grant2", 32'(grant), 32'h4);
        req = 4'b0000;
        step(2);
        check("t4 back held", 32'(dut.state), 32'(HELD));
        core_reset = 1'b1;
        step();
        core_reset = 1'b0;
        step();
        check("t4 release", 32'(dut.state), 32'(RELEASE));
        check("t4 halt low", 32'(cpu_halt), 32'h0);
        cpu_halted = 1'b0;
        step();
        check("t4 idle", 32'(dut.state), 32'(IDLE));

        // request withdrawn before it is granted
        req = 4'b0010;
        step();
        req = 4'b0000;
        step();
        cpu_halted = 1'b1;
        step();
        check("t5 dropped grant", 32'(grant), 32'h0);
        check("t5 dropped release", 32'(dut.state), 32'(RELEASE));
        cpu_halted = 1'b0;
        step();

        // OSD pause option
        osd_status = 1'b1;
        options = 2'b01;
        step();
        check("t5 osd halt", 32'(cpu_halt), 32'h1);
        cpu_halted = 1'b1;
        step();
        check("t5 osd held", 32'(dut.state), 32'(HELD));
        osd_status = 1'b0;
        step();
        check("t5 osd release", 32'(cpu_halt), 32'h0);
        cpu_halted = 1'b0;
        options = 2'b00;
        step();

        // asynchronous reset mid-grant
        cpu_halted = 1'b1;
        req = 4'b0001;
        step(2);
        check("t6 grant before rst", 32'(grant), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("t6 async grant", 32'(grant), 32'h0);
        check("t6 async halt", 32'(cpu_halt), 32'h0);
`ifdef PAUSE_ARB_DIM_EN
        check("t6 async dim", 32'(dim_video), 32'h0);
`endif
        req = 4'b0000;
        step();
        reset_n = 1'b1;
        step();

`ifdef PAUSE_ARB_DIM_EN
        // dim after DIM_LIMIT paused cycles
        options = 2'b10;
        user_button = 1'b1;
        step();
        user_button = 1'b0;
        step();
        check("t7 paused", 32'(paused), 32'h1);
        first = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (dim_video && first == 0) first = i;
        end
        check("t7 dim cycle", 32'(first), 32'd101);
        options = 2'b00;
        step();
        check("t7 dim clear", 32'(dim_video), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
